// File: rtl/cache_ctrl_wt_assoc_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared types and width helpers for the write-through cache controller
// (cache_ctrl_wt_assoc) and its tag store (cache_tag_store).
//   state_t    : controller FSM states
//   tag_width  : tag bits left over after index and offset
//   way_width  : width of a way-select field (at least 1 bit)
// -----------------------------------------------------------------------------
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;

  function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

  // A direct-mapped cache still carries a 1-bit way field so port widths never collapse to 0.
  function automatic int way_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_ctrl_wt_assoc_tag_store.sv
// -----------------------------------------------------------------------------
// cache_tag_store
// Tag / valid / LRU state for a 1- or 2-way set-associative cache.
// Ports:
//   clk, reset_n        clock, async active-low reset (clears everything)
//   lk_index, lk_tag    combinational lookup address
//   lk_hit, lk_hit_way  hit flag and hitting way (lowest way wins)
//   lk_victim_way       first invalid way of the set, else the LRU way
//   up_alloc            write up_tag into (up_index, up_way) and set valid
//   up_touch            mark up_way most recently used in set up_index
//   flush               clear every valid bit
// -----------------------------------------------------------------------------
module cache_tag_store
  import cache_pkg::*;
#(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 3,
  parameter int WAYS    = 1,
  parameter int WAY_W   = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INDEX_W-1:0] lk_index,
  input  logic [TAG_W-1:0]   lk_tag,
  output logic               lk_hit,
  output logic [WAY_W-1:0]   lk_hit_way,
  output logic [WAY_W-1:0]   lk_victim_way,
  input  logic               up_alloc,
  input  logic               up_touch,
  input  logic [INDEX_W-1:0] up_index,
  input  logic [WAY_W-1:0]   up_way,
  input  logic [TAG_W-1:0]   up_tag,
  input  logic               flush
);

  localparam int SETS = 1 << INDEX_W;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAY_W-1:0] lru_q   [SETS];   // way to evict next in each set

  // Walk ways from the top down so the lowest matching way is the one left standing.
  always_comb begin
    // NOTE: every output gets a value before any branch so no latch is inferred.
    lk_hit     = 1'b0;
    lk_hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[lk_index][w] && (tag_q[lk_index][w] == lk_tag)) begin
        lk_hit     = 1'b1;
        lk_hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    lk_victim_way = (WAYS == 2) ? lru_q[lk_index] : '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[lk_index][w]) lk_victim_way = WAY_W'(w);
    end
  end

  // NOTE: these arrays are flops, not RAM, so they take the async reset; valid
  // must read 0 the moment reset_n drops, and tags/LRU are cleared with it so
  // the state is fully defined.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        lru_q[s]   <= '0;
        for (int w = 0; w < WAYS; w++) tag_q[s][w] <= '0;
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (flush) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end
      if (up_alloc) begin
        tag_q[up_index][up_way]   <= up_tag;
        valid_q[up_index][up_way] <= 1'b1;
      end
      if (up_touch) begin
        lru_q[up_index] <= (WAYS == 2) ? ~up_way : '0;
      end
    end
  end

endmodule

// File: rtl/cache_ctrl_wt_assoc.sv
// -----------------------------------------------------------------------------
// cache_ctrl_wt_assoc
// Write-through, no-write-allocate cache controller (tag/valid/LRU only) for
// the single-cycle core. 1- or 2-way set associative, per-set LRU.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   mem_read, mem_write     core load/store request (held while stall=1)
//   word_addr               {tag, index, offset}
//   flush                   invalidate all lines (only when no request)
//   mem_ready               main memory completes the current request
//   stall, miss             core freeze / access-misses indication
//   fill, fill_way          strobe: write memory block into data array way
//   wr_hit, hit_way         strobe: store hit update / way that hit
//   mem_rd_req, mem_wr_req  block read / write-through request to memory
// Optional feature, macro CACHE_STATS_EN: adds clr_stats and saturating
// 32-bit counters rd_hit_cnt, rd_miss_cnt, wr_cnt.
// -----------------------------------------------------------------------------
module cache_ctrl_wt_assoc
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int OFFSET_W = 2,
  parameter int INDEX_W  = 5,
  parameter int WAYS     = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        mem_read,
  input  logic                        mem_write,
  input  logic [ADDR_W-1:0]           word_addr,
  input  logic                        flush,
  input  logic                        mem_ready,
  output logic                        stall,
  output logic                        miss,
  output logic                        fill,
  output logic                        wr_hit,
  output logic [way_width(WAYS)-1:0]  hit_way,
  output logic [way_width(WAYS)-1:0]  fill_way,
  output logic                        mem_rd_req,
  output logic                        mem_wr_req
`ifdef CACHE_STATS_EN
  ,
  input  logic                        clr_stats,
  output logic [31:0]                 rd_hit_cnt,
  output logic [31:0]                 rd_miss_cnt,
  output logic [31:0]                 wr_cnt
`endif
);

  localparam int TAG_W = tag_width(ADDR_W, INDEX_W, OFFSET_W);
  localparam int WAY_W = way_width(WAYS);

  if ((WAYS != 1) && (WAYS != 2)) begin : g_bad_ways
    $error("cache_ctrl_wt_assoc: WAYS must be 1 or 2");
  end

  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic [OFFSET_W-1:0] offset_unused;   // word select belongs to the data array
  assign index         = word_addr[OFFSET_W +: INDEX_W];
  assign tag           = word_addr[ADDR_W-1 -: TAG_W];
  assign offset_unused = word_addr[OFFSET_W-1:0];

  state_t           state_q, state_d;
  logic             lk_hit;
  logic [WAY_W-1:0] lk_hit_way, lk_victim_way;
  logic             up_alloc, up_touch, flush_clr;
  logic [WAY_W-1:0] up_way;

  cache_tag_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .WAYS    (WAYS),
    .WAY_W   (WAY_W)
  ) u_tag_store (
    .clk           (clk),
    .reset_n       (reset_n),
    .lk_index      (index),
    .lk_tag        (tag),
    .lk_hit        (lk_hit),
    .lk_hit_way    (lk_hit_way),
    .lk_victim_way (lk_victim_way),
    .up_alloc      (up_alloc),
    .up_touch      (up_touch),
    .up_index      (index),
    .up_way        (up_way),
    .up_tag        (tag),
    .flush         (flush_clr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Outputs are gated by reset_n so memory requests drop the instant reset
  // asserts, even while the core is still holding its request.
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    miss       = 1'b0;
    fill       = 1'b0;
    wr_hit     = 1'b0;
    hit_way    = '0;
    fill_way   = '0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    up_alloc   = 1'b0;
    up_touch   = 1'b0;
    up_way     = lk_hit_way;
    flush_clr  = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        IDLE: begin
          if (mem_write) begin
            stall      = 1'b1;
            mem_wr_req = 1'b1;
            miss       = !lk_hit;
            if (lk_hit) hit_way = lk_hit_way;
            state_d    = WR_THRU;
          end else if (mem_read) begin
            if (lk_hit) begin
              hit_way  = lk_hit_way;
              up_touch = 1'b1;
            end else begin
              miss       = 1'b1;
              stall      = 1'b1;
              mem_rd_req = 1'b1;
              state_d    = RD_MISS;
            end
          end else begin
            // A flush arriving with a request waits until the request is done.
            flush_clr = flush;
          end
        end
        RD_MISS: begin
          mem_rd_req = 1'b1;
          miss       = 1'b1;
          stall      = !mem_ready;
          if (mem_ready) begin
            fill     = 1'b1;
            fill_way = lk_victim_way;
            up_way   = lk_victim_way;
            up_alloc = 1'b1;
            up_touch = 1'b1;
            state_d  = IDLE;
          end
        end
        WR_THRU: begin
          mem_wr_req = 1'b1;
          miss       = !lk_hit;
          stall      = !mem_ready;
          if (lk_hit) hit_way = lk_hit_way;
          if (mem_ready) begin
            wr_hit   = lk_hit;   // no-write-allocate: a store miss leaves tags untouched
            up_touch = lk_hit;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic rd_hit_ev, rd_miss_ev, wr_ev;
  assign rd_hit_ev  = (state_q == IDLE) && mem_read && !mem_write && lk_hit;
  assign rd_miss_ev = (state_q == IDLE) && (state_d == RD_MISS);
  assign wr_ev      = (state_q == WR_THRU) && mem_ready;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic ev);
    return (ev && (v != '1)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_hit_cnt  <= '0;
      rd_miss_cnt <= '0;
      wr_cnt      <= '0;
    end else if (clr_stats) begin
      rd_hit_cnt  <= '0;
      rd_miss_cnt <= '0;
      wr_cnt      <= '0;
    end else begin
      rd_hit_cnt  <= sat_inc(rd_hit_cnt, rd_hit_ev);
      rd_miss_cnt <= sat_inc(rd_miss_cnt, rd_miss_ev);
      wr_cnt      <= sat_inc(wr_cnt, wr_ev);
    end
  end
`endif

endmodule
